// File: rtl/presc_counter.sv
// CE-gated prescaler feeding a bounded up/down counter (saturate or wrap),
// with synchronous clear/load, terminal count and a registered boundary event.
module presc_counter #(
  parameter int SIZE      = 4,
  parameter int MAX_VAL   = 9,
  parameter int DIV       = 1,
  parameter bit WRAP_MODE = 1'b0
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            CE,
  input  logic            CLR,
  input  logic            LD,
  input  logic [SIZE-1:0] D,
  input  logic            DN,
  output logic [SIZE-1:0] Q,
  output logic            TC,
  output logic            EVT
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(DIV - 1);
  localparam logic [SIZE-1:0] MAX_Q  = SIZE'(MAX_VAL);
  localparam logic [SIZE-1:0] ONE_Q  = SIZE'(1);

  logic [PW-1:0]   p;
  logic            tick;
  logic [SIZE-1:0] q_nxt;
  logic            evt_nxt;
  logic [SIZE-1:0] d_clamped;

  // CE is a plain qualifier: no ready/backpressure, every CE-high edge is consumed.
  assign tick      = CE && (p == P_LAST);
  assign d_clamped = (D > MAX_Q) ? MAX_Q : D;
  assign TC        = DN ? (Q == '0) : (Q == MAX_Q);

  always_comb begin
    q_nxt   = Q;
    evt_nxt = 1'b0;
    if (tick) begin
      if (!DN) begin
        if (Q < MAX_Q) begin
          q_nxt   = Q + ONE_Q;
          evt_nxt = !WRAP_MODE && (Q == MAX_Q - ONE_Q);
        end else if (WRAP_MODE) begin
          q_nxt   = '0;
          evt_nxt = 1'b1;
        end
      end else begin
        if (Q != '0) begin
          q_nxt   = Q - ONE_Q;
          evt_nxt = !WRAP_MODE && (Q == ONE_Q);
        end else if (WRAP_MODE) begin
          q_nxt   = MAX_Q;
          evt_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      Q   <= '0;
      p   <= '0;
      EVT <= 1'b0;
    end else if (CLR) begin
      Q   <= '0;
      p   <= '0;
      EVT <= 1'b0;
    end else if (LD) begin
      Q   <= d_clamped;
      p   <= '0;
      EVT <= 1'b0;
    end else begin
      // P freezes while CE is low so gaps stretch the step period.
      if (CE) p <= tick ? '0 : p + PW'(1);
      Q   <= q_nxt;
      EVT <= evt_nxt;
    end
  end

endmodule

// File: tb/tb_presc_counter.sv
// Directed bench for presc_counter: four configurations share one stimulus bus,
// a queue-based scoreboard compares the selected instance after each edge.
module tb_presc_counter;

  localparam int W = 6;

  logic       clk = 1'b0;
  logic       r;
  logic       ce, clr, ld, dn;
  logic [3:0] d;
  int         sel;

  logic [3:0] q0, q1, q2, q3;
  logic       tc0, tc1, tc2, tc3;
  logic       evt0, evt1, evt2, evt3;
  logic [W-1:0] act;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  presc_counter #(.SIZE(4), .MAX_VAL(9), .DIV(1), .WRAP_MODE(1'b0)) u_sat (
    .CLK(clk), .R(r), .CE(ce), .CLR(clr), .LD(ld), .D(d), .DN(dn),
    .Q(q0), .TC(tc0), .EVT(evt0));
  presc_counter #(.SIZE(4), .MAX_VAL(9), .DIV(1), .WRAP_MODE(1'b1)) u_wrap (
    .CLK(clk), .R(r), .CE(ce), .CLR(clr), .LD(ld), .D(d), .DN(dn),
    .Q(q1), .TC(tc1), .EVT(evt1));
  presc_counter #(.SIZE(4), .MAX_VAL(9), .DIV(4), .WRAP_MODE(1'b0)) u_div4 (
    .CLK(clk), .R(r), .CE(ce), .CLR(clr), .LD(ld), .D(d), .DN(dn),
    .Q(q2), .TC(tc2), .EVT(evt2));
  presc_counter #(.SIZE(4), .MAX_VAL(9), .DIV(3), .WRAP_MODE(1'b0)) u_div3 (
    .CLK(clk), .R(r), .CE(ce), .CLR(clr), .LD(ld), .D(d), .DN(dn),
    .Q(q3), .TC(tc3), .EVT(evt3));

  always_comb begin
    act = {q0, evt0, tc0};
    case (sel)
      1:       act = {q1, evt1, tc1};
      2:       act = {q2, evt2, tc2};
      3:       act = {q3, evt3, tc3};
      default: act = {q0, evt0, tc0};
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got q=%0d evt=%0b tc=%0b expected q=%0d evt=%0b tc=%0b",
               name, a[5:2], a[1], a[0], e[5:2], e[1], e[0]);
    end
  endtask

  // driver: apply inputs, queue the state expected after the coming edge
  task automatic step(input logic ce_i, input logic clr_i, input logic ld_i,
                      input logic [3:0] d_i, input logic dn_i,
                      input logic [3:0] eq, input logic ee, input logic et,
                      input string tag);
    ce = ce_i; clr = clr_i; ld = ld_i; d = d_i; dn = dn_i;
    exp_q.push_back({eq, ee, et});
    tag_q.push_back(tag);
    @(posedge clk);
    #3;
  endtask

  // monitor: one expected entry per edge, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, act, e);
    end
  end

  initial begin
    logic [3:0] eq;
    r = 1'b1; ce = 1'b0; clr = 1'b0; ld = 1'b0; dn = 1'b0; d = '0; sel = 0;
    repeat (2) @(posedge clk);
    #3;
    r = 1'b0;
    #1;
    check("reset_dn0", act, {4'd0, 1'b0, 1'b0});
    dn = 1'b1;
    #1;
    check("reset_dn1_tc", act, {4'd0, 1'b0, 1'b1});
    dn = 1'b0;

    // saturating up count, DIV=1
    sel = 0;
    for (int k = 1; k <= 12; k++) begin
      eq = (k > 9) ? 4'd9 : 4'(k);
      step(1, 0, 0, 0, 0, eq, k == 9, eq == 4'd9, "sat_up");
    end

    // wrap mode up through MAX, then down through 0
    sel = 1;
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, "wrap_clr");
    for (int k = 1; k <= 11; k++) begin
      eq = (k == 10) ? 4'd0 : (k == 11) ? 4'd1 : 4'(k);
      step(1, 0, 0, 0, 0, eq, k == 10, eq == 4'd9, "wrap_up");
    end
    step(1, 0, 0, 0, 1, 4'd0, 0, 1, "wrap_dn_to0");
    step(1, 0, 0, 0, 1, 4'd9, 1, 0, "wrap_dn_wrap");
    step(1, 0, 0, 0, 1, 4'd8, 0, 0, "wrap_dn_8");

    // DIV=4 prescale with a 3-cycle CE gap after P=2
    sel = 2;
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, "div4_clr");
    for (int k = 1; k <= 8; k++)
      step(1, 0, 0, 0, 0, 4'(k / 4), 0, 0, "div4_run");
    step(1, 0, 0, 0, 0, 4'd2, 0, 0, "div4_p1");
    step(1, 0, 0, 0, 0, 4'd2, 0, 0, "div4_p2");
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 0, 0, 4'd2, 0, 0, "div4_gap");
    step(1, 0, 0, 0, 0, 4'd2, 0, 0, "div4_p3");
    step(1, 0, 0, 0, 0, 4'd3, 0, 0, "div4_step_after_gap");

    // LD restarts the prescale phase
    step(1, 0, 0, 0, 0, 4'd3, 0, 0, "div4_p1b");
    step(1, 0, 0, 0, 0, 4'd3, 0, 0, "div4_p2b");
    step(1, 0, 1, 4'd6, 0, 4'd6, 0, 0, "div4_ld");
    for (int k = 0; k < 3; k++)
      step(1, 0, 0, 0, 0, 4'd6, 0, 0, "div4_ld_phase");
    step(1, 0, 0, 0, 0, 4'd7, 0, 0, "div4_ld_step");

    // load/clear priority, DIV=1 saturate
    sel = 0;
    step(0, 0, 1, 4'd15, 0, 4'd9, 0, 1, "ld_clamp");
    step(0, 1, 1, 4'd5, 0, 4'd0, 0, 0, "clr_over_ld");
    step(1, 0, 1, 4'd4, 0, 4'd4, 0, 0, "ld_over_tick");

    // down saturate to 0
    step(0, 0, 1, 4'd2, 0, 4'd2, 0, 0, "dn_ld2");
    step(1, 0, 0, 0, 1, 4'd1, 0, 0, "dn_1");
    step(1, 0, 0, 0, 1, 4'd0, 1, 1, "dn_enter0");
    step(1, 0, 0, 0, 1, 4'd0, 0, 1, "dn_hold0a");
    step(1, 0, 0, 0, 1, 4'd0, 0, 1, "dn_hold0b");

    // async reset mid-count, DIV=3
    sel = 3;
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, "div3_clr");
    step(0, 0, 1, 4'd5, 0, 4'd5, 0, 0, "div3_ld5");
    step(1, 0, 0, 0, 0, 4'd5, 0, 0, "div3_p1");
    #2;
    r = 1'b1;
    #1;
    check("async_reset", act, {4'd0, 1'b0, 1'b0});
    #1;
    r = 1'b0;
    step(1, 0, 0, 0, 0, 4'd0, 0, 0, "div3_post_p1");
    step(1, 0, 0, 0, 0, 4'd0, 0, 0, "div3_post_p2");
    step(1, 0, 0, 0, 0, 4'd1, 0, 0, "div3_post_step");

    ce = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
